// File: rtl/turn_pkg.sv
// Shared types for the heading turn tracker: FSM state encoding and turn direction.
package turn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    TRACK = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } turn_state_t;

  typedef enum logic {
    RIGHT = 1'b0,
    LEFT  = 1'b1
  } turn_dir_t;

endpackage

// File: rtl/heading_unwrap.sv
// Turns a modular heading stream into signed per-sample steps in the commanded direction.
// Holds the previous in-range sample and wraps each difference into (-MOD/2, MOD/2].
module heading_unwrap
  import turn_pkg::*;
#(
  parameter int HEADING_W   = 16,
  parameter int HEADING_MOD = 360
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [HEADING_W-1:0]   heading,
  input  logic                   heading_valid,
  input  logic                   track_en,
  input  turn_dir_t              dir,
  output logic                   sample_ok,
  output logic                   step_valid,
  output logic signed [HEADING_W:0] step
);

  localparam int SW = HEADING_W + 1;
  localparam logic signed [SW-1:0] MOD_S  = SW'(HEADING_MOD);
  localparam logic signed [SW-1:0] HALF_S = SW'(HEADING_MOD / 2);

  logic [HEADING_W-1:0]   prev;
  logic signed [SW-1:0]   raw;
  logic signed [SW-1:0]   wrapped;

  assign sample_ok  = heading_valid && ({1'b0, heading} < SW'(HEADING_MOD));
  assign step_valid = sample_ok && track_en;

  // prev follows every in-range sample; the top only consumes steps in TRACK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else if (sample_ok) begin
      prev <= heading;
    end
  end

  always_comb begin
    raw     = $signed({1'b0, heading}) - $signed({1'b0, prev});
    wrapped = raw;
    if (raw <= -HALF_S) begin
      wrapped = raw + MOD_S;
    end else if (raw > HALF_S) begin
      wrapped = raw - MOD_S;
    end
    step = (dir == LEFT) ? -wrapped : wrapped;
  end

endmodule

// File: rtl/heading_turn_tracker.sv
// Tracks a commanded in-place turn against the IMU heading and flags completion,
// timeout or abort. Owns the saturating accumulator, confirm and timeout counters.
module heading_turn_tracker
  import turn_pkg::*;
#(
  parameter int HEADING_W      = 16,
  parameter int HEADING_MOD    = 360,
  parameter int ACC_W          = 24,
  parameter int CONFIRM        = 2,
  parameter int TIMEOUT_CYCLES = 200_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    dir,
  input  logic [HEADING_W-1:0]    target,
  input  logic                    abort,
  input  logic [HEADING_W-1:0]    heading,
  input  logic                    heading_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic signed [ACC_W-1:0] progress,
  output logic [2:0]              state_dbg
);

  localparam int CNT_W = $clog2(CONFIRM + 1);
  localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CONF_N  = CNT_W'(CONFIRM);
  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};

  turn_state_t           state, state_n;
  turn_dir_t             dir_q, dir_n;
  logic [HEADING_W-1:0]  target_q, target_n;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [TO_W-1:0]       to_q, to_n;

  logic                  sample_ok;
  logic                  step_valid;
  logic signed [HEADING_W:0] step;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] sat;
  logic signed [ACC_W:0] tgt_s;
  logic                  qualifies;
  logic                  to_expire;

  heading_unwrap #(
    .HEADING_W   (HEADING_W),
    .HEADING_MOD (HEADING_MOD)
  ) u_unwrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .heading       (heading),
    .heading_valid (heading_valid),
    .track_en      (state == TRACK),
    .dir           (dir_q),
    .sample_ok     (sample_ok),
    .step_valid    (step_valid),
    .step          (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dir_q    <= RIGHT;
      target_q <= '0;
      acc      <= '0;
      cnt_q    <= '0;
      to_q     <= '0;
    end else begin
      state    <= state_n;
      dir_q    <= dir_n;
      target_q <= target_n;
      acc      <= acc_n;
      cnt_q    <= cnt_n;
      to_q     <= to_n;
    end
  end

  // Saturating accumulate plus threshold test, used only when a TRACK step arrives
  always_comb begin
    sum = $signed({acc[ACC_W-1], acc}) + (ACC_W+1)'(step);
    if (sum > ACC_MAX) begin
      sat = ACC_MAX;
    end else if (sum < ACC_MIN) begin
      sat = ACC_MIN;
    end else begin
      sat = sum;
    end
    tgt_s     = $signed({{(ACC_W+1-HEADING_W){1'b0}}, target_q});
    qualifies = (sat >= tgt_s);
    to_expire = (TIMEOUT_CYCLES != 0) && (to_q == TO_W'(1));
  end

  // Priority: abort, then confirming sample, then timeout, then start
  always_comb begin
    state_n  = state;
    dir_n    = dir_q;
    target_n = target_q;
    acc_n    = acc;
    cnt_n    = cnt_q;
    to_n     = to_q;

    if (abort) begin
      state_n = IDLE;
      acc_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE, DONE, FAULT: begin
          if (start) begin
            acc_n = '0;
            cnt_n = '0;
            if (target == '0) begin
              state_n = DONE;
            end else begin
              state_n  = ARM;
              dir_n    = turn_dir_t'(dir);
              target_n = target;
              to_n     = TO_LOAD;
            end
          end
        end
        ARM: begin
          to_n = to_q - TO_W'(1);
          if (sample_ok) begin
            state_n = TRACK;
          end
          if (to_expire) begin
            state_n = FAULT;
          end
        end
        TRACK: begin
          to_n = to_q - TO_W'(1);
          if (step_valid) begin
            acc_n = sat[ACC_W-1:0];
            if (qualifies) begin
              cnt_n = cnt_q + CNT_W'(1);
              if (cnt_q + CNT_W'(1) == CONF_N) begin
                state_n = DONE;
              end
            end else begin
              cnt_n = '0;
            end
          end
          if (to_expire && state_n != DONE) begin
            state_n = FAULT;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy      = (state == ARM) || (state == TRACK);
  assign done      = (state == DONE);
  assign timeout   = (state == FAULT);
  assign progress  = acc;
  assign state_dbg = state;

endmodule

// File: tb/tb_heading_turn_tracker.sv
// Self-checking bench for heading_turn_tracker: directed scenarios plus randomized
// turns, compared every cycle against a behavioural model of the turn rules.
module tb_heading_turn_tracker;
  import turn_pkg::*;

  localparam int HW   = 16;
  localparam int MOD  = 360;
  localparam int AW   = 24;
  localparam int CONF = 2;
  localparam int TO   = 1000;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 dir;
  logic [HW-1:0]        target;
  logic                 abort;
  logic [HW-1:0]        heading;
  logic                 heading_valid;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic signed [AW-1:0] progress;
  logic [2:0]           state_dbg;

  int checks = 0;
  int errors = 0;

  turn_state_t m_state;
  longint      m_acc;
  int          m_prev;
  int          m_cnt;
  int          m_tgt;
  bit          m_left;
  longint      cyc;
  longint      m_start_cyc;

  int h_walk;
  int delta;

  heading_turn_tracker #(
    .HEADING_W      (HW),
    .HEADING_MOD    (MOD),
    .ACC_W          (AW),
    .CONFIRM        (CONF),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .dir           (dir),
    .target        (target),
    .abort         (abort),
    .heading       (heading),
    .heading_valid (heading_valid),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .progress      (progress),
    .state_dbg     (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Shortest signed angular difference, in (-MOD/2, MOD/2]
  function automatic int wrapStep(input int h, input int p);
    int d;
    d = ((h - p) % MOD + MOD) % MOD;
    if (d > MOD / 2) d -= MOD;
    return d;
  endfunction

  function automatic longint clampAcc(input longint v);
    longint hi, lo;
    hi = (longint'(1) << (AW - 1)) - 1;
    lo = -(longint'(1) << (AW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic modelReset();
    m_state = IDLE;
    m_acc   = 0;
    m_cnt   = 0;
  endtask

  task automatic modelEdge();
    bit ok;
    bit confirmed;
    int s;
    cyc++;
    ok = heading_valid && (int'(heading) < MOD);
    confirmed = 1'b0;
    if (abort) begin
      m_state = IDLE;
      m_acc   = 0;
      m_cnt   = 0;
    end else begin
      case (m_state)
        IDLE, DONE, FAULT: begin
          if (start) begin
            m_acc = 0;
            m_cnt = 0;
            if (target == 0) begin
              m_state = DONE;
            end else begin
              m_state     = ARM;
              m_left      = dir;
              m_tgt       = int'(target);
              m_start_cyc = cyc;
            end
          end
        end
        ARM: begin
          if (ok) begin
            m_prev  = int'(heading);
            m_state = TRACK;
          end
          if (cyc - m_start_cyc == TO) m_state = FAULT;
        end
        TRACK: begin
          if (ok) begin
            s = wrapStep(int'(heading), m_prev);
            if (m_left) s = -s;
            m_acc  = clampAcc(m_acc + s);
            m_prev = int'(heading);
            if (m_acc >= m_tgt) m_cnt++;
            else m_cnt = 0;
            if (m_cnt >= CONF) begin
              m_state   = DONE;
              confirmed = 1'b1;
            end
          end
          if (!confirmed && (cyc - m_start_cyc == TO)) m_state = FAULT;
        end
        default: m_state = IDLE;
      endcase
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".busy"}, 32'(busy), 32'((m_state == ARM) || (m_state == TRACK)));
    checkOutput({tag, ".done"}, 32'(done), 32'(m_state == DONE));
    checkOutput({tag, ".timeout"}, 32'(timeout), 32'(m_state == FAULT));
    checkOutput({tag, ".progress"}, 32'(progress), 32'(m_acc));
    checkOutput({tag, ".state"}, 32'(state_dbg), 32'(m_state));
  endtask

  task automatic applyStimulus(input string tag, input bit st, input bit d, input int tgt,
                               input bit ab, input int h, input bit hv);
    start         = st;
    dir           = d;
    target        = HW'(tgt);
    abort         = ab;
    heading       = HW'(h);
    heading_valid = hv;
    @(posedge clk);
    modelEdge();
    #1;
    compareAll(tag);
    start         = 1'b0;
    abort         = 1'b0;
    heading_valid = 1'b0;
  endtask

  task automatic startCmd(input string tag, input bit d, input int tgt);
    applyStimulus(tag, 1'b1, d, tgt, 1'b0, 0, 1'b0);
  endtask

  task automatic sample(input string tag, input int h);
    applyStimulus(tag, 1'b0, 1'b0, 0, 1'b0, h, 1'b1);
  endtask

  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic doAbort(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 0, 1'b1, 0, 1'b0);
  endtask

  initial begin
    int rw_h[6]   = '{300, 330, 359, 10, 30, 31};
    int rw_p[6]   = '{0, 30, 59, 70, 90, 91};
    int lt_h[5]   = '{20, 0, 350, 290, 289};
    int lt_p[5]   = '{0, 20, 30, 90, 91};

    start = 1'b0; dir = 1'b0; target = '0; abort = 1'b0;
    heading = '0; heading_valid = 1'b0;
    cyc = 0; m_start_cyc = 0; m_prev = 0; m_tgt = 0; m_left = 1'b0;
    modelReset();
    rst_n = 1'b0;
    #12;
    compareAll("reset");
    checkOutput("reset.progress0", 32'(progress), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    startCmd("rw.start", 1'b0, 90);
    checkOutput("rw.busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      sample("rw", rw_h[i]);
      checkOutput("rw.prog_const", 32'(progress), 32'(rw_p[i]));
    end
    checkOutput("rw.done", 32'(done), 32'd1);
    checkOutput("rw.busy_low", 32'(busy), 32'd0);
    idleCycles("rw.hold", 3);
    checkOutput("rw.frozen", 32'(progress), 32'd91);

    startCmd("lt.start", 1'b1, 90);
    for (int i = 0; i < 5; i++) begin
      sample("lt", lt_h[i]);
      checkOutput("lt.prog_const", 32'(progress), 32'(lt_p[i]));
    end
    checkOutput("lt.done", 32'(done), 32'd1);

    startCmd("jit.start", 1'b0, 90);
    sample("jit", 0);
    sample("jit", 90);
    sample("jit", 89);
    sample("jit", 90);
    checkOutput("jit.not_done", 32'(done), 32'd0);
    sample("jit", 91);
    checkOutput("jit.done", 32'(done), 32'd1);

    startCmd("inv.start", 1'b0, 90);
    sample("inv", 100);
    sample("inv", 120);
    sample("inv", 400);
    checkOutput("inv.prog_hold", 32'(progress), 32'd20);
    sample("inv", 130);
    checkOutput("inv.prog_step", 32'(progress), 32'd30);
    doAbort("abort");
    checkOutput("abort.state", 32'(state_dbg), 32'd0);
    checkOutput("abort.progress", 32'(progress), 32'd0);

    applyStimulus("startabort", 1'b1, 1'b0, 90, 1'b1, 0, 1'b0);
    checkOutput("startabort.state", 32'(state_dbg), 32'd0);

    startCmd("to.start", 1'b0, 90);
    idleCycles("to.wait", TO - 1);
    checkOutput("to.early", 32'(timeout), 32'd0);
    idleCycles("to.fire", 1);
    checkOutput("to.timeout", 32'(timeout), 32'd1);
    checkOutput("to.busy", 32'(busy), 32'd0);
    startCmd("to.restart", 1'b0, 90);
    checkOutput("to.rearm", 32'(state_dbg), 32'd1);
    checkOutput("to.cleared", 32'(timeout), 32'd0);
    doAbort("to.abort");

    startCmd("zero", 1'b0, 0);
    checkOutput("zero.done", 32'(done), 32'd1);

    startCmd("arst.start", 1'b0, 90);
    sample("arst", 0);
    sample("arst", 50);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst.busy", 32'(busy), 32'd0);
    checkOutput("arst.progress", 32'(progress), 32'd0);
    checkOutput("arst.state", 32'(state_dbg), 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int cmd = 0; cmd < 40; cmd++) begin
      h_walk = int'($urandom_range(0, MOD - 1));
      applyStimulus("rnd.start", 1'b1, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 300)),
                    1'b0, 0, 1'b0);
      for (int c = 0; c < 150; c++) begin
        delta = int'($urandom_range(0, 30)) - 5;
        if (m_left) delta = -delta;
        h_walk = ((h_walk + delta) % MOD + MOD) % MOD;
        if ($urandom_range(0, 19) == 0) begin
          applyStimulus("rnd.inv", 1'b0, 1'b0, 0, 1'b0, MOD + int'($urandom_range(0, 1000)), 1'b1);
        end else begin
          applyStimulus("rnd", ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 200)), ($urandom_range(0, 99) == 0),
                        h_walk, ($urandom_range(0, 9) < 6));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/heading_turn_tracker.md
# heading_turn_tracker

Tracks a commanded in-place turn against the IMU heading stream and reports when the requested angle has been swept. It sits between the heading output of `uart_imu_new` / `uart_arduino` and the `imu_heading` input of `motor_controller`, replacing the ad-hoc capture-and-compare logic in top level. It generalises that logic with:
- parametrised heading width and modulus;
- wrap-safe unwrapped accumulation;
- per-command direction and target angle;
- sample confirmation, a timeout and abort.

## Interface
Parameters:
- `HEADING_W`, 16, heading sample width (unsigned).
- `HEADING_MOD`, 360, heading modulus; valid samples are 0..HEADING_MOD-1.
- `ACC_W`, 24, signed accumulated-progress width.
- `CONFIRM`, 2, consecutive qualifying samples required for done (≥1).
- `TIMEOUT_CYCLES`, 200_000_000, cycles from accepted start to fault; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle command pulse.
- `dir`  in  1  0 = right (heading increasing), 1 = left; sampled on accepted start.
- `target`  in  HEADING_W  turn magnitude in heading units; sampled on accepted start.
- `abort`  in  1  cancel the current command.
- `heading`  in  HEADING_W  latest heading sample.
- `heading_valid`  in  1  one-cycle strobe qualifying `heading`.
- `busy`  out  1  high in ARM and TRACK.
- `done`  out  1  level, high in DONE.
- `timeout`  out  1  level, high in FAULT.
- `progress`  out  ACC_W  signed swept angle in the commanded direction.
- `state_dbg`  out  3  state encoding, for LEDs.

## Operation
- States: IDLE, ARM, TRACK, DONE, FAULT.
- Accepted start:
  - `start` is accepted in IDLE, DONE or FAULT, and ignored in ARM and TRACK.
  - When `target` is 0, the block goes straight to DONE.
  - Otherwise the block goes to ARM. It latches `dir` and `target`, clears `progress` and the confirm count, and loads the timeout counter.
- ARM: the first valid sample becomes the reference (`prev`), then the block moves to TRACK. `progress` stays 0.
- TRACK, per valid sample `h`:
  - `raw = h - prev`, computed signed at HEADING_W+1 bits.
  - Wrap `raw` into (-MOD/2, MOD/2]: add MOD if `raw` ≤ -MOD/2; subtract MOD if `raw` > MOD/2.
  - Negate the step if `dir` = 1, then add it to the accumulator. `prev` ← `h`.
  - If the new accumulator ≥ `target`, increment the confirm count; otherwise clear it.
  - When the count reaches CONFIRM, go to DONE.
- Invalid samples: a strobe with `heading` ≥ HEADING_MOD is ignored completely in every state.
- Accumulator: it saturates at the signed ACC_W limits and never wraps.
- Timeout: the counter decrements each cycle in ARM and TRACK. When it reaches 0, the block goes to FAULT.
- `abort`: any state goes to IDLE, with `progress` cleared, `done` = 0 and `timeout` = 0.
- Same-cycle priority: `abort` > confirming sample > timeout expiry > `start`. A `start` coinciding with `abort` is dropped.
- DONE and FAULT hold, with `progress` frozen, until the next accepted start or abort.

## Timing
- Reset (async, `rst_n` low): state IDLE; `busy`, `done`, `timeout`, `progress` and `state_dbg` are all 0. Asserting reset mid-TRACK takes effect immediately, without waiting for `clk`.
- Accepted start: `busy` rises on the next edge.
- `progress` updates on the edge after its `heading_valid` cycle.
- `done` rises on the edge after the confirming sample, and `busy` falls on the same edge.
- Timeout: `timeout` asserts exactly TIMEOUT_CYCLES cycles after the start-accept edge.
- `heading_valid` may be asserted on consecutive cycles. There is no back-pressure, and every valid sample is processed.

## Structure
- Package `turn_pkg` holds:
  - the `turn_state_t` enum (IDLE=0, ARM=1, TRACK=2, DONE=3, FAULT=4);
  - the `turn_dir_t` enum (RIGHT=0, LEFT=1).
- Sub-module `heading_unwrap` holds `prev`, performs the modulus wrap and direction negation, and emits a signed step plus `step_valid`. It is parametrised by HEADING_W and HEADING_MOD.
- The top FSM owns the accumulator, the confirm counter and the timeout counter.

## Test plan
Unless stated otherwise: HEADING_MOD = 360, CONFIRM = 2, TIMEOUT_CYCLES = 0.
- Right turn across the wrap, target 90: samples 300, 330, 359, 10, 30, 31 → `progress` 0, 30, 59, 70, 90, 91. `done` rises one cycle after sample 31, `progress` = 91, `busy` = 0.
- Left turn, target 90: samples 20, 0, 350, 290, 289 → `progress` 0, 20, 30, 90, 91; `done` asserts after 289.
- Jitter: right turn from 0 with samples 90, 89, 90, 91 → the confirm count resets at 89; `done` asserts only after 91.
- Invalid sample 400 mid-track → `progress` unchanged, `prev` unchanged; the next valid sample steps from the last valid sample.
- TIMEOUT_CYCLES = 1000 with no samples → `timeout` = 1 and `busy` = 0 exactly 1000 cycles after start; a new start clears it and re-enters ARM.
- Abort and reset:
  - `abort` mid-TRACK → next edge IDLE, `progress` = 0.
  - `start` and `abort` in the same cycle → stays IDLE.
  - `rst_n` low mid-TRACK → all outputs 0 asynchronously.
